// File: rtl/uart_prog_loader.sv
// UART program loader: hunts a start word in the received byte stream, then
// assembles MSB-first words and writes them to instruction memory from
// address 0 while holding the CPU halted. A stop word ends the load, with or
// without a CPU reset pulse. An inter-byte timeout or memory overflow aborts
// the load.
module uart_prog_loader #(
   parameter int                      WORD_BYTES     = 3,
   parameter int                      ADDR_W         = 8,
   parameter logic [8*WORD_BYTES-1:0] START_WORD     = 'h0000FF,
   parameter logic [8*WORD_BYTES-1:0] STOP_RST_WORD  = 'h000FFF,
   parameter logic [8*WORD_BYTES-1:0] STOP_HOLD_WORD = 'h000F00,
   parameter int                      TIMEOUT_CYCLES = 1_000_000,
   parameter int                      RST_PULSE_CYC  = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [7:0]                rx_data,
   input  logic                      rx_valid,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_addr,
   output logic [8*WORD_BYTES-1:0]   mem_wdata,
   output logic                      cpu_halt,
   output logic                      cpu_rst,
   output logic [ADDR_W:0]           word_count,
   output logic                      done,
   output logic                      error
);

   localparam int WORD_W = 8 * WORD_BYTES;
   localparam int BC_W   = $clog2(WORD_BYTES + 1);
   localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
   localparam int PC_W   = $clog2(RST_PULSE_CYC + 1);

   localparam logic [BC_W-1:0]   LAST_BYTE = BC_W'(WORD_BYTES - 1);
   localparam logic [BC_W-1:0]   FULL_SYNC = BC_W'(WORD_BYTES);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam logic [PC_W-1:0]   PC_LAST   = PC_W'(RST_PULSE_CYC - 1);
   localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_PULSE = 2'd2;

   logic [1:0]        state;
   logic [WORD_W-1:0] window;     // sliding start-hunt window, reused for word assembly
   logic [BC_W-1:0]   sync_cnt;   // bytes seen in IDLE, saturating at WORD_BYTES
   logic [BC_W-1:0]   byte_cnt;   // position within the word being assembled
   logic [TO_W-1:0]   to_cnt;
   logic [PC_W-1:0]   pulse_cnt;
   logic [ADDR_W-1:0] addr;

   logic [WORD_W-1:0] win_next;
   logic              start_hit;

   // New byte enters at the LSB; the oldest byte falls off the top.
   assign win_next  = WORD_W'({window, rx_data});
   assign start_hit = rx_valid && (sync_cnt >= LAST_BYTE) && (win_next == START_WORD);

   // Loader FSM: start hunt, word assembly/write, abort detection, reset pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= S_IDLE;
         window     <= '0;
         sync_cnt   <= '0;
         byte_cnt   <= '0;
         to_cnt     <= '0;
         pulse_cnt  <= '0;
         addr       <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         cpu_halt   <= 1'b0;
         cpu_rst    <= 1'b0;
         word_count <= '0;
         done       <= 1'b0;
         error      <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         case (state)
            S_IDLE: begin
               if (rx_valid) begin
                  window <= win_next;
                  if (sync_cnt != FULL_SYNC) sync_cnt <= sync_cnt + 1'b1;
                  if (start_hit) begin
                     state      <= S_LOAD;
                     done       <= 1'b0;
                     error      <= 1'b0;
                     word_count <= '0;
                     addr       <= '0;
                     byte_cnt   <= '0;
                     to_cnt     <= '0;
                     cpu_halt   <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               if (rx_valid) begin
                  to_cnt <= '0;
                  window <= win_next;
                  if (byte_cnt == LAST_BYTE) begin
                     byte_cnt <= '0;
                     if (win_next == STOP_RST_WORD) begin
                        cpu_halt  <= 1'b0;
                        done      <= 1'b1;
                        cpu_rst   <= 1'b1;
                        pulse_cnt <= '0;
                        state     <= S_PULSE;
                     end else if (win_next == STOP_HOLD_WORD) begin
                        cpu_halt <= 1'b0;
                        done     <= 1'b1;
                        state    <= S_IDLE;
                        window   <= '0;
                        sync_cnt <= '0;
                     end else if (win_next == START_WORD) begin
                        // Restart: reload from address 0 without leaving LOAD.
                        addr       <= '0;
                        word_count <= '0;
                     end else if (word_count == DEPTH) begin
                        error    <= 1'b1;
                        cpu_halt <= 1'b0;
                        state    <= S_IDLE;
                        window   <= '0;
                        sync_cnt <= '0;
                     end else begin
                        mem_we     <= 1'b1;
                        mem_addr   <= addr;
                        mem_wdata  <= win_next;
                        addr       <= addr + 1'b1;
                        word_count <= word_count + 1'b1;
                     end
                  end else begin
                     byte_cnt <= byte_cnt + 1'b1;
                  end
               end else if (to_cnt == TO_LAST) begin
                  // Line went quiet mid-load: drop any partial word.
                  error    <= 1'b1;
                  cpu_halt <= 1'b0;
                  state    <= S_IDLE;
                  window   <= '0;
                  sync_cnt <= '0;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            S_PULSE: begin
               if (pulse_cnt == PC_LAST) begin
                  cpu_rst  <= 1'b0;
                  state    <= S_IDLE;
                  window   <= '0;
                  sync_cnt <= '0;
               end else begin
                  pulse_cnt <= pulse_cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_prog_loader.sv
// Bench for uart_prog_loader: three configurations (default words, tiny
// memory, 4-byte words) driven from one shared byte stream, checked against
// a queue-based reference model of the load protocol.
module tb_uart_prog_loader;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   int         sel;

   always #5 clk = ~clk;

   // DUT A: defaults, short timeout
   logic we_a, halt_a, crst_a, done_a, err_a;
   logic [7:0] addr_a; logic [23:0] wd_a; logic [8:0] wc_a;
   // DUT B: 4-word memory
   logic we_b, halt_b, crst_b, done_b, err_b;
   logic [1:0] addr_b; logic [23:0] wd_b; logic [2:0] wc_b;
   // DUT C: 4-byte words
   logic we_c, halt_c, crst_c, done_c, err_c;
   logic [7:0] addr_c; logic [31:0] wd_c; logic [8:0] wc_c;

   logic v_a, v_b, v_c;
   assign v_a = rx_valid && (sel == 0);
   assign v_b = rx_valid && (sel == 1);
   assign v_c = rx_valid && (sel == 2);

   uart_prog_loader #(.TIMEOUT_CYCLES(100)) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(v_a),
      .mem_we(we_a), .mem_addr(addr_a), .mem_wdata(wd_a), .cpu_halt(halt_a),
      .cpu_rst(crst_a), .word_count(wc_a), .done(done_a), .error(err_a));

   uart_prog_loader #(.ADDR_W(2), .TIMEOUT_CYCLES(100)) dut_b (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(v_b),
      .mem_we(we_b), .mem_addr(addr_b), .mem_wdata(wd_b), .cpu_halt(halt_b),
      .cpu_rst(crst_b), .word_count(wc_b), .done(done_b), .error(err_b));

   uart_prog_loader #(.WORD_BYTES(4), .START_WORD(32'h000000FF),
                      .STOP_RST_WORD(32'h00000FFF), .STOP_HOLD_WORD(32'h00000F00),
                      .TIMEOUT_CYCLES(100)) dut_c (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(v_c),
      .mem_we(we_c), .mem_addr(addr_c), .mem_wdata(wd_c), .cpu_halt(halt_c),
      .cpu_rst(crst_c), .word_count(wc_c), .done(done_c), .error(err_c));

   int          we_v[3], addr_v[3], halt_v[3], crst_v[3], wc_v[3], done_v[3], err_v[3];
   logic [31:0] wd_v[3];
   assign we_v[0] = int'(we_a);   assign we_v[1] = int'(we_b);   assign we_v[2] = int'(we_c);
   assign addr_v[0] = int'(addr_a); assign addr_v[1] = int'(addr_b); assign addr_v[2] = int'(addr_c);
   assign wd_v[0] = {8'h00, wd_a}; assign wd_v[1] = {8'h00, wd_b}; assign wd_v[2] = wd_c;
   assign halt_v[0] = int'(halt_a); assign halt_v[1] = int'(halt_b); assign halt_v[2] = int'(halt_c);
   assign crst_v[0] = int'(crst_a); assign crst_v[1] = int'(crst_b); assign crst_v[2] = int'(crst_c);
   assign wc_v[0] = int'(wc_a);   assign wc_v[1] = int'(wc_b);   assign wc_v[2] = int'(wc_c);
   assign done_v[0] = int'(done_a); assign done_v[1] = int'(done_b); assign done_v[2] = int'(done_c);
   assign err_v[0] = int'(err_a);  assign err_v[1] = int'(err_b);  assign err_v[2] = int'(err_c);

   int n_chk = 0;
   int n_fail = 0;
   int we_bad = 0;
   int crst_cnt[3] = '{0, 0, 0};

   int          cap_k[$];
   int          cap_a[$];
   logic [31:0] cap_d[$];

   // Write/pulse monitor, sampled mid-cycle.
   always @(negedge clk) begin
      for (int k = 0; k < 3; k++) begin
         if (we_v[k] != 0) begin
            cap_k.push_back(k);
            cap_a.push_back(addr_v[k]);
            cap_d.push_back(wd_v[k]);
            if (halt_v[k] == 0) we_bad++;
         end
         if (crst_v[k] != 0) crst_cnt[k]++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   logic [7:0]  seq[$];
   int          exp_a[$];
   logic [31:0] exp_d[$];
   int          m_done, m_err, m_pulse, m_wc;

   // Protocol-level model: find first start word, then walk whole words.
   function automatic void model(input int wb, input int depth, input logic [31:0] st,
                                 input logic [31:0] srst, input logic [31:0] shold);
      logic [63:0] win = '0;
      logic [31:0] mask, w;
      int k = -1;
      int addr = 0;
      exp_a.delete(); exp_d.delete();
      m_done = 0; m_err = 0; m_pulse = 0; m_wc = 0;
      mask = (wb == 4) ? 32'hFFFF_FFFF : 32'h00FF_FFFF;
      for (int i = 0; i < seq.size(); i++) begin
         win = (win << 8) | {56'h0, seq[i]};
         if (i + 1 >= wb && (win[31:0] & mask) == st) begin
            k = i;
            break;
         end
      end
      if (k < 0) return;
      for (int i = k + 1; i + wb <= seq.size(); i += wb) begin
         w = '0;
         for (int t = 0; t < wb; t++) w = (w << 8) | {24'h0, seq[i + t]};
         if (w == srst) begin m_done = 1; m_pulse = 1; return; end
         if (w == shold) begin m_done = 1; return; end
         if (w == st) begin addr = 0; m_wc = 0; end
         else if (m_wc == depth) begin m_err = 1; return; end
         else begin
            exp_a.push_back(addr);
            exp_d.push_back(w);
            addr++;
            m_wc++;
         end
      end
   endfunction

   function automatic logic [31:0] rnd_word(input int wb);
      logic [31:0] w;
      w = $urandom();
      if (wb == 3) w[31:24] = 8'h00;
      if (w == 32'h0000_00FF || w == 32'h0000_0FFF || w == 32'h0000_0F00) w = w ^ 32'h0012_3400;
      return w;
   endfunction

   task automatic push_word(input logic [31:0] w, input int wb);
      for (int t = wb - 1; t >= 0; t--) seq.push_back(8'(w >> (8 * t)));
   endtask

   // Send seq; halt must be high after byte sidx and low again after byte eidx.
   task automatic send_seq(input int sidx, input int eidx, input int max_gap);
      int hbad = 0;
      for (int i = 0; i < seq.size(); i++) begin
         rx_data = seq[i];
         rx_valid = 1'b1;
         @(posedge clk); #1;
         rx_valid = 1'b0;
         if (halt_v[sel] != ((i >= sidx && i < eidx) ? 1 : 0)) hbad++;
         repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      end
      chk("halt_window", hbad, 0);
   endtask

   task automatic clear_caps();
      cap_k.delete(); cap_a.delete(); cap_d.delete();
   endtask

   task automatic compare_load(input string tag);
      chk({tag, "_nwr"}, cap_d.size(), exp_d.size());
      for (int i = 0; i < exp_d.size() && i < cap_d.size(); i++) begin
         chk({tag, "_dut"}, cap_k[i], sel);
         chk({tag, "_addr"}, cap_a[i], exp_a[i]);
         chk({tag, "_data"}, cap_d[i], exp_d[i]);
      end
      chk({tag, "_done"}, done_v[sel], m_done);
      chk({tag, "_error"}, err_v[sel], m_err);
      chk({tag, "_wc"}, wc_v[sel], m_wc);
      chk({tag, "_halt_end"}, halt_v[sel], 0);
      clear_caps();
   endtask

   task automatic finish_pulse(input string tag);
      repeat (30) @(posedge clk);
      #1;
      chk({tag, "_crst_cycles"}, crst_cnt[sel], (m_pulse != 0) ? 16 : 0);
      chk({tag, "_crst_end"}, crst_v[sel], 0);
   endtask

   initial begin
      int s, e;
      rst = 1'b0; rx_valid = 1'b0; rx_data = 8'h00; sel = 0;
      repeat (3) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk("rst_we", we_v[k], 0);
         chk("rst_halt", halt_v[k], 0);
         chk("rst_crst", crst_v[k], 0);
         chk("rst_wc", wc_v[k] + done_v[k] + err_v[k] + addr_v[k], 0);
         chk("rst_wdata", wd_v[k], 0);
      end
      rst = 1'b1;
      @(posedge clk); #1;

      // 1) basic load with reset-pulse stop
      sel = 0; clear_caps(); crst_cnt[0] = 0;
      seq = '{8'h00, 8'h00, 8'hFF, 8'hF0, 8'h00, 8'h6C, 8'hAC, 8'hF2, 8'h8F, 8'h00, 8'h0F, 8'hFF};
      model(3, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(2, 11, 2);
      compare_load("t1");
      finish_pulse("t1");

      // 2) stray byte before start, hold-stop
      clear_caps(); crst_cnt[0] = 0;
      seq = '{8'h55, 8'h00, 8'h00, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h00, 8'h0F, 8'h00};
      model(3, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(3, 9, 2);
      compare_load("t2");
      finish_pulse("t2");

      // 3) timeout mid-word, then recovery load
      clear_caps();
      seq = '{8'h00, 8'h00, 8'hFF, 8'h12, 8'h34};
      send_seq(2, 99, 1);
      repeat (60) @(posedge clk);
      #1;
      chk("t3_no_early_timeout", err_v[0], 0);
      chk("t3_halt_held", halt_v[0], 1);
      repeat (100) @(posedge clk);
      #1;
      chk("t3_timeout_err", err_v[0], 1);
      chk("t3_timeout_halt", halt_v[0], 0);
      chk("t3_no_write", cap_d.size(), 0);
      seq = '{8'h00, 8'h00, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h00, 8'h0F, 8'h00};
      model(3, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(2, 8, 1);
      compare_load("t3r");

      // 4) overflow on 4-word memory
      sel = 1; clear_caps();
      seq = '{8'h00, 8'h00, 8'hFF};
      for (int i = 1; i <= 5; i++) push_word(i, 3);
      model(3, 4, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(2, seq.size() - 1, 2);
      compare_load("t4");

      // 5) reset mid-load, then fresh random load with reset-pulse stop
      sel = 0; clear_caps();
      seq = '{8'h00, 8'h00, 8'hFF, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E};
      send_seq(2, 99, 1);
      chk("t5_pre_nwr", cap_d.size(), 1);
      chk("t5_pre_data", (cap_d.size() > 0) ? cap_d[0] : 32'hDEAD, 32'h0A0B0C);
      clear_caps();
      rst = 1'b0;
      #1;
      chk("t5_rst_halt", halt_v[0], 0);
      chk("t5_rst_wc", wc_v[0], 0);
      chk("t5_rst_flags", done_v[0] + err_v[0] + crst_v[0] + we_v[0], 0);
      chk("t5_rst_addr", addr_v[0], 0);
      chk("t5_rst_wdata", wd_v[0], 0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("t5_no_write_after_rst", cap_d.size(), 0);
      crst_cnt[0] = 0;
      seq = '{8'h00, 8'h00, 8'hFF};
      s = seq.size() - 1;
      for (int i = 0; i < int'($urandom_range(8, 3)); i++) push_word(rnd_word(3), 3);
      push_word(32'hFFF, 3);
      e = seq.size() - 1;
      model(3, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(s, e, 2);
      compare_load("t5");
      finish_pulse("t5");

      // restart inside a load returns to address 0
      clear_caps(); crst_cnt[0] = 0;
      seq = '{8'h00, 8'h00, 8'hFF};
      s = seq.size() - 1;
      for (int i = 0; i < 3; i++) push_word(rnd_word(3), 3);
      push_word(32'hFF, 3);
      for (int i = 0; i < 2; i++) push_word(rnd_word(3), 3);
      push_word(32'hF00, 3);
      e = seq.size() - 1;
      model(3, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(s, e, 1);
      compare_load("restart");
      finish_pulse("restart");

      // 6) 4-byte words, back-to-back bytes
      sel = 2; clear_caps(); crst_cnt[2] = 0;
      seq = '{8'h00, 8'h00, 8'h00, 8'hFF};
      s = seq.size() - 1;
      push_word(32'hDEADBEEF, 4);
      for (int i = 0; i < 6; i++) push_word(rnd_word(4), 4);
      push_word(32'hF00, 4);
      e = seq.size() - 1;
      model(4, 256, 32'hFF, 32'hFFF, 32'hF00);
      send_seq(s, e, 0);
      compare_load("t6");
      finish_pulse("t6");

      chk("we_outside_load", we_bad, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
